// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, device ACK.
// One byte in flight; tx_valid outside IDLE is dropped; exactly one done/ack_err/timeout pulse per accepted byte.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);
   localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]    r_bit, w_bit_nxt;
   logic [7:0]    r_data, w_data_nxt;
   logic          r_par, w_par_nxt;
   logic          r_ack_bad, w_ack_bad_nxt;
   logic          r_clk_oe, w_clk_oe_nxt;
   logic          r_data_oe, w_data_oe_nxt;
   logic          r_done, w_done_nxt;
   logic          r_ack_err, w_ack_err_nxt;
   logic          r_timeout, w_timeout_nxt;
   logic          r_clk_s1, r_clk_s2, r_clk_d;
   logic          r_dat_s1, r_dat_s2;
   logic          w_fall;
   logic          w_timed;

   // Sync flops reset to 1 (idle bus) so release from reset never looks like an edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_clk_d  <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk_i;
         r_clk_s2 <= r_clk_s1;
         r_clk_d  <= r_clk_s2;
         r_dat_s1 <= ps2_data_i;
         r_dat_s2 <= r_dat_s1;
      end
   end

   assign w_fall  = r_clk_d & ~r_clk_s2;
   assign w_timed = (r_state == S_REQ) || (r_state == S_SEND) ||
                    (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_bit_nxt     = r_bit;
      w_data_nxt    = r_data;
      w_par_nxt     = r_par;
      w_ack_bad_nxt = r_ack_bad;
      w_clk_oe_nxt  = r_clk_oe;
      w_data_oe_nxt = r_data_oe;
      w_done_nxt    = 1'b0;
      w_ack_err_nxt = 1'b0;
      w_timeout_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (tx_valid) begin
               w_state_nxt   = S_INHIBIT;
               w_cnt_nxt     = '0;
               w_data_nxt    = tx_data;
               w_par_nxt     = ~^tx_data;
               w_clk_oe_nxt  = 1'b1;
               w_data_oe_nxt = (INHIBIT_CYCLES <= 1);
            end
         end
         S_INHIBIT: begin
            w_cnt_nxt = r_cnt + CW'(1);
            // Outputs are registered: raise the start bit one cycle early so it is low during the last inhibit cycle.
            if (r_cnt == INH_PRE) w_data_oe_nxt = 1'b1;
            if (r_cnt == INH_LAST) begin
               w_state_nxt   = S_REQ;
               w_cnt_nxt     = '0;
               w_clk_oe_nxt  = 1'b0;
               w_data_oe_nxt = 1'b1;
            end
         end
         S_REQ: begin
            w_cnt_nxt   = r_cnt + CW'(1);
            w_bit_nxt   = '0;
            w_state_nxt = S_SEND;
         end
         S_SEND: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_fall) begin
               w_bit_nxt = r_bit + 4'd1;
               if (r_bit < 4'd8) begin
                  w_data_oe_nxt = ~r_data[r_bit[2:0]];
               end else if (r_bit == 4'd8) begin
                  w_data_oe_nxt = ~r_par;
               end else begin
                  w_data_oe_nxt = 1'b0;
                  w_state_nxt   = S_ACK;
               end
            end
         end
         S_ACK: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_fall) begin
               w_ack_bad_nxt = r_dat_s2;
               w_state_nxt   = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_clk_s2 && r_dat_s2) begin
               w_done_nxt    = ~r_ack_bad;
               w_ack_err_nxt = r_ack_bad;
               w_state_nxt   = S_IDLE;
               w_cnt_nxt     = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Timeout overrides whatever the state decoded this cycle, including an edge.
      if (w_timed && (r_cnt == TO_LAST)) begin
         w_state_nxt   = S_IDLE;
         w_cnt_nxt     = '0;
         w_clk_oe_nxt  = 1'b0;
         w_data_oe_nxt = 1'b0;
         w_done_nxt    = 1'b0;
         w_ack_err_nxt = 1'b0;
         w_timeout_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_data    <= '0;
         r_par     <= 1'b0;
         r_ack_bad <= 1'b0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_done    <= 1'b0;
         r_ack_err <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit     <= w_bit_nxt;
         r_data    <= w_data_nxt;
         r_par     <= w_par_nxt;
         r_ack_bad <= w_ack_bad_nxt;
         r_clk_oe  <= w_clk_oe_nxt;
         r_data_oe <= w_data_oe_nxt;
         r_done    <= w_done_nxt;
         r_ack_err <= w_ack_err_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign tx_ready    = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign done        = r_done;
   assign ack_err     = r_ack_err;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares each observed frame and result pulse against a byte-level reference.
module tb_ps2_host_tx;
   localparam int INH  = 20;
   localparam int TOC  = 5000;
   localparam int HALF = 100;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       pin_clk, pin_data;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int n_ack   = 0;
   int n_to    = 0;

   // Open-drain bus with pull-ups.
   assign pin_clk  = dev_clk & ~ps2_clk_oe;
   assign pin_data = dev_data & ~ps2_data_oe;

   always #5 clk = ~clk;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOC)) dut (
      .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .ps2_clk_i(pin_clk), .ps2_data_i(pin_data), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout)
   );

   always @(negedge clk) begin
      if (done === 1'b1) n_done++;
      if (ack_err === 1'b1) n_ack++;
      if (timeout === 1'b1) n_to++;
   end

   // Reference frame as the device sees it: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      tx_data = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
   endtask

   task automatic dev_frame(input logic ack_bit, input int inj_bit, input int rst_bit,
                            output logic [10:0] bits, output int inh, output logic pre_oe,
                            output logic last_oe, output logic mid_busy, output bit ok);
      int t;
      bits = '0; inh = 0; pre_oe = 1'b0; last_oe = 1'b0; mid_busy = 1'b0; ok = 1'b1; t = 0;
      while (ps2_clk_oe !== 1'b1 && t < 50) begin tick(1); t++; end
      while (ps2_clk_oe === 1'b1 && inh < 1000) begin
         pre_oe = last_oe;
         last_oe = ps2_data_oe;
         inh++;
         tick(1);
      end
      if (inh == 0 || inh >= 1000) ok = 1'b0;
      bits[0] = pin_data;
      tick(50);
      for (int i = 1; i <= 10; i++) begin
         dev_clk = 1'b0;
         if (i == rst_bit) begin
            tick(20);
            return;
         end
         if (i == inj_bit) begin
            tx_data = 8'h55;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            tick(HALF - 1);
         end else begin
            tick(HALF);
         end
         dev_clk = 1'b1;
         bits[i] = pin_data;
         if (i == 5) mid_busy = busy;
         tick(HALF);
      end
      tick(50);
      dev_data = ack_bit;
      tick(50);
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      tick(50);
      dev_data = 1'b1;
   endtask

   task automatic test_reset;
      tick(3);
      n_tests++; if ({tx_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL reset_ready_busy got=%b exp=10", {tx_ready, busy}); end
      n_tests++; if ({ps2_clk_oe, ps2_data_oe, done, ack_err, timeout} !== 5'b0) begin n_fail++; $display("FAIL reset_outputs got=%b exp=00000", {ps2_clk_oe, ps2_data_oe, done, ack_err, timeout}); end
      rstn = 1'b1;
      tick(5);
      n_tests++; if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin n_fail++; $display("FAIL post_reset_idle got=%b exp=1000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}); end
   endtask

   task automatic test_send_bytes;
      logic [7:0]  list [5];
      logic [10:0] bits, exp;
      int inh, d0, a0, t0;
      logic pre_oe, last_oe, mid_busy;
      bit ok;
      list[0] = 8'hED; list[1] = 8'hFF; list[2] = 8'h00; list[3] = 8'($urandom); list[4] = 8'($urandom);
      for (int n = 0; n < 5; n++) begin
         d0 = n_done; a0 = n_ack; t0 = n_to;
         exp = model_frame(list[n]);
         send_byte(list[n]);
         dev_frame(1'b0, 0, 0, bits, inh, pre_oe, last_oe, mid_busy, ok);
         tick(20);
         n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL frame_bound byte=%h got=%0d exp=1", list[n], ok); end
         n_tests++; if (inh !== INH) begin n_fail++; $display("FAIL inhibit_len byte=%h got=%0d exp=%0d", list[n], inh, INH); end
         n_tests++; if ({pre_oe, last_oe} !== 2'b01) begin n_fail++; $display("FAIL start_timing byte=%h got=%b exp=01", list[n], {pre_oe, last_oe}); end
         n_tests++; if (bits !== exp) begin n_fail++; $display("FAIL frame_bits byte=%h got=%b exp=%b", list[n], bits, exp); end
         n_tests++; if (mid_busy !== 1'b1) begin n_fail++; $display("FAIL busy_mid byte=%h got=%b exp=1", list[n], mid_busy); end
         n_tests++; if ({n_done - d0, n_ack - a0, n_to - t0} !== {32'd1, 32'd0, 32'd0}) begin n_fail++; $display("FAIL result_pulses byte=%h got done=%0d ack=%0d to=%0d exp 1/0/0", list[n], n_done - d0, n_ack - a0, n_to - t0); end
         n_tests++; if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin n_fail++; $display("FAIL end_idle byte=%h got=%b exp=100", list[n], {tx_ready, ps2_clk_oe, ps2_data_oe}); end
      end
   endtask

   task automatic test_ack_err;
      logic [7:0]  b;
      logic [10:0] bits;
      int inh, d0, a0, t0;
      logic pre_oe, last_oe, mid_busy;
      bit ok;
      b = 8'($urandom);
      d0 = n_done; a0 = n_ack; t0 = n_to;
      send_byte(b);
      dev_frame(1'b1, 0, 0, bits, inh, pre_oe, last_oe, mid_busy, ok);
      tick(20);
      n_tests++; if (bits !== model_frame(b)) begin n_fail++; $display("FAIL ackerr_bits byte=%h got=%b exp=%b", b, bits, model_frame(b)); end
      n_tests++; if ({n_done - d0, n_ack - a0, n_to - t0} !== {32'd0, 32'd1, 32'd0}) begin n_fail++; $display("FAIL ackerr_pulses got done=%0d ack=%0d to=%0d exp 0/1/0", n_done - d0, n_ack - a0, n_to - t0); end
      n_tests++; if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin n_fail++; $display("FAIL ackerr_release got=%b exp=100", {tx_ready, ps2_clk_oe, ps2_data_oe}); end
   endtask

   task automatic test_timeout;
      int c, d0, a0, t0;
      d0 = n_done; a0 = n_ack; t0 = n_to;
      send_byte(8'($urandom));
      c = 0;
      while (ps2_clk_oe === 1'b1 && c < 200) begin tick(1); c++; end
      c = 0;
      while (timeout !== 1'b1 && c < TOC + 100) begin tick(1); c++; end
      n_tests++; if (c !== TOC) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=%0d", c, TOC); end
      n_tests++; if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin n_fail++; $display("FAIL timeout_release got=%b exp=1000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}); end
      tick(5);
      n_tests++; if ({n_done - d0, n_ack - a0, n_to - t0} !== {32'd0, 32'd0, 32'd1}) begin n_fail++; $display("FAIL timeout_pulses got done=%0d ack=%0d to=%0d exp 0/0/1", n_done - d0, n_ack - a0, n_to - t0); end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  b;
      logic [10:0] bits;
      int inh, d0, a0, t0, hi;
      logic pre_oe, last_oe, mid_busy;
      bit ok;
      b = 8'($urandom) ^ 8'h0F;
      d0 = n_done; a0 = n_ack; t0 = n_to;
      send_byte(b);
      dev_frame(1'b0, 3, 0, bits, inh, pre_oe, last_oe, mid_busy, ok);
      hi = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (ps2_clk_oe === 1'b1) hi++;
      end
      n_tests++; if (bits !== model_frame(b)) begin n_fail++; $display("FAIL b2b_bits byte=%h got=%b exp=%b", b, bits, model_frame(b)); end
      n_tests++; if ({n_done - d0, n_ack - a0, n_to - t0} !== {32'd1, 32'd0, 32'd0}) begin n_fail++; $display("FAIL b2b_pulses got done=%0d ack=%0d to=%0d exp 1/0/0", n_done - d0, n_ack - a0, n_to - t0); end
      n_tests++; if (hi !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_second got clk_oe_cycles=%0d busy=%b exp 0/0", hi, busy); end
   endtask

   task automatic test_reset_mid;
      logic [7:0]  b;
      logic [10:0] bits;
      int inh, d0, a0, t0;
      logic pre_oe, last_oe, mid_busy;
      bit ok;
      b = 8'($urandom) & 8'hEF;
      d0 = n_done; a0 = n_ack; t0 = n_to;
      send_byte(b);
      dev_frame(1'b0, 0, 5, bits, inh, pre_oe, last_oe, mid_busy, ok);
      n_tests++; if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_data_oe got=%b exp=1", ps2_data_oe); end
      #3 rstn = 1'b0;
      #1;
      n_tests++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin n_fail++; $display("FAIL rst_async_release got=%b exp=001", {ps2_clk_oe, ps2_data_oe, tx_ready}); end
      dev_clk = 1'b1;
      tick(3);
      rstn = 1'b1;
      tick(50);
      n_tests++; if ({n_done - d0, n_ack - a0, n_to - t0} !== {32'd0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL rst_no_pulse got done=%0d ack=%0d to=%0d exp 0/0/0", n_done - d0, n_ack - a0, n_to - t0); end
      n_tests++; if ({tx_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL rst_ready got=%b exp=10", {tx_ready, busy}); end
      d0 = n_done;
      send_byte(8'hF4);
      dev_frame(1'b0, 0, 0, bits, inh, pre_oe, last_oe, mid_busy, ok);
      tick(20);
      n_tests++; if (bits !== model_frame(8'hF4)) begin n_fail++; $display("FAIL rst_f4_bits got=%b exp=%b", bits, model_frame(8'hF4)); end
      n_tests++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL rst_f4_done got=%0d exp=1", n_done - d0); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not complete got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_send_bytes();
      test_ack_err();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
